cci_mpf_shim_req_mux: RTL and testbench

CCI_MPF_SHIM_REQ_MUX -- requirements
Module: cci_mpf_shim_req_mux

---
 rtl/cci_mpf_shim_req_mux_pkg.sv | 24 ++
 rtl/cci_mpf_shim_rr_arb.sv | 49 ++++
 rtl/cci_mpf_shim_req_mux.sv | 166 ++++++++++++++++
 tb/tb_cci_mpf_shim_req_mux.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_shim_req_mux_pkg.sv
// Shared types and sizing helpers for the CCI MPF request multiplexer.
// Port indices are carried one bit wider than needed so that a response
// tag can be compared against N_PORTS itself without wrapping.
package cci_mpf_shim_req_mux_pkg;

    localparam int MAX_PORTS          = 8;
    localparam int STAT_W             = 32;
    localparam int DEFAULT_MAX_ACTIVE = 128;

    // Width of the port-index field carried in the top Mdata bits.
    function automatic int idx_width(input int n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction

    // Width of a per-port outstanding-request counter (0..max_active inclusive).
    function automatic int active_cnt_width(input int max_active);
        return $clog2(max_active + 1);
    endfunction

    typedef logic [$clog2(MAX_PORTS+1)-1:0]                   port_idx_t;
    typedef logic [$clog2(DEFAULT_MAX_ACTIVE+1)-1:0]          active_cnt_t;
    typedef logic [STAT_W-1:0]                                stat_cnt_t;

endpackage

// File: rtl/cci_mpf_shim_rr_arb.sv
// Round-robin arbiter: one-hot grant among requesters, search starting at an
// internal pointer that moves to winner+1 only when something is granted.
module cci_mpf_shim_rr_arb
    import cci_mpf_shim_req_mux_pkg::*;
#(
    parameter int  N  = 2,
    localparam int PW = idx_width(N)
)(
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic          grant_any,
    output logic [PW-1:0] grant_idx
);

    logic [PW-1:0] ptr_reg;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest requester.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                grant_idx = PW'(j);
                grant_any = 1'b1;
            end
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j] && (PW'(j) >= ptr_reg)) begin
                grant_idx = PW'(j);
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign grant[gi] = grant_any && (grant_idx == PW'(gi));
    end

    // Pointer advances past the winner, wrapping at N.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else if (grant_any) begin
            ptr_reg <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

endmodule

// File: rtl/cci_mpf_shim_req_mux.sv
// Merges N_PORTS AFU request streams onto one FIU request channel, tagging the
// top Mdata bits with the source port and routing responses back by that tag.
// Per-port outstanding counts throttle each port at MAX_ACTIVE_REQS.
// Optional per-port grant statistics: define CCI_MPF_SHIM_REQ_MUX_STATS_EN.
module cci_mpf_shim_req_mux
    import cci_mpf_shim_req_mux_pkg::*;
#(
    parameter int N_PORTS         = 2,
    parameter int MDATA_WIDTH     = 16,
    parameter int HDR_WIDTH       = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_ACTIVE_REQS = 128
)(
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [N_PORTS-1:0]             afu_req_valid,
    input  logic [N_PORTS*HDR_WIDTH-1:0]   afu_req_hdr,
    input  logic [N_PORTS*MDATA_WIDTH-1:0] afu_req_mdata,
    output logic [N_PORTS-1:0]             afu_req_ready,
    output logic                           fiu_req_valid,
    output logic [HDR_WIDTH-1:0]           fiu_req_hdr,
    output logic [MDATA_WIDTH-1:0]         fiu_req_mdata,
    input  logic                           fiu_req_almfull,
    input  logic                           fiu_rsp_valid,
    input  logic [MDATA_WIDTH-1:0]         fiu_rsp_mdata,
    input  logic [DATA_WIDTH-1:0]          fiu_rsp_data,
    output logic [N_PORTS-1:0]             afu_rsp_valid,
    output logic [N_PORTS*MDATA_WIDTH-1:0] afu_rsp_mdata,
    output logic [N_PORTS*DATA_WIDTH-1:0]  afu_rsp_data,
    output logic                           tag_error,
    output logic [N_PORTS*32-1:0]          stat_req_count
);

    localparam int PW    = idx_width(N_PORTS);
    localparam int CNT_W = active_cnt_width(MAX_ACTIVE_REQS);
    localparam int LOW_W = MDATA_WIDTH - PW;

    logic [N_PORTS-1:0]    eligible;
    logic [N_PORTS-1:0]    grant;
    logic                  grant_any;
    logic [PW-1:0]         grant_idx;
    logic [HDR_WIDTH-1:0]  sel_hdr;
    logic [LOW_W-1:0]      sel_mdata_low;
    logic [PW-1:0]         rsp_port;
    logic                  rsp_in_range;
    logic [N_PORTS-1:0]    rsp_hit;
    logic [N_PORTS*PW-1:0] unused_mdata_top;

    logic                   fiu_req_valid_reg;
    logic [HDR_WIDTH-1:0]   fiu_req_hdr_reg;
    logic [MDATA_WIDTH-1:0] fiu_req_mdata_reg;
    logic [N_PORTS-1:0]     rsp_valid_reg;
    logic [MDATA_WIDTH-1:0] rsp_mdata_reg;
    logic [DATA_WIDTH-1:0]  rsp_data_reg;
    logic                   tag_error_reg;

    cci_mpf_shim_rr_arb #(.N(N_PORTS)) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (eligible),
        .grant     (grant),
        .grant_any (grant_any),
        .grant_idx (grant_idx)
    );

    // Ready is the grant itself; eligibility already folds in reset and almfull.
    assign afu_req_ready = grant;

    // Pick the granted port's header and the Mdata bits below the tag field.
    always_comb begin
        sel_hdr       = '0;
        sel_mdata_low = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) begin
                sel_hdr       = afu_req_hdr[i*HDR_WIDTH +: HDR_WIDTH];
                sel_mdata_low = afu_req_mdata[i*MDATA_WIDTH +: LOW_W];
            end
        end
    end

    // Request valid is the only control bit on the FIU side.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fiu_req_valid_reg <= 1'b0;
        end else begin
            fiu_req_valid_reg <= grant_any;
        end
    end

    // Request payload: the source port index overwrites the top Mdata bits.
    always_ff @(posedge clk) begin
        fiu_req_hdr_reg   <= sel_hdr;
        fiu_req_mdata_reg <= {grant_idx, sel_mdata_low};
    end

    assign fiu_req_valid = fiu_req_valid_reg;
    assign fiu_req_hdr   = fiu_req_hdr_reg;
    assign fiu_req_mdata = fiu_req_mdata_reg;

    assign rsp_port     = fiu_rsp_mdata[MDATA_WIDTH-1 -: PW];
    assign rsp_in_range = port_idx_t'(rsp_port) < port_idx_t'(N_PORTS);

    // Response valid routing and the sticky bad-tag flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid_reg <= '0;
            tag_error_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= rsp_hit;
            if (fiu_rsp_valid && !rsp_in_range) begin
                tag_error_reg <= 1'b1;
            end
        end
    end

    // Response payload is shared by all ports; only the valid bit is steered.
    always_ff @(posedge clk) begin
        rsp_mdata_reg <= {{PW{1'b0}}, fiu_rsp_mdata[LOW_W-1:0]};
        rsp_data_reg  <= fiu_rsp_data;
    end

    assign afu_rsp_valid = rsp_valid_reg;
    assign tag_error     = tag_error_reg;

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
        logic [CNT_W-1:0] active_cnt_reg;

        assign rsp_hit[gi]  = fiu_rsp_valid && (rsp_port == PW'(gi));
        assign eligible[gi] = reset_n && !fiu_req_almfull && afu_req_valid[gi] &&
                              (active_cnt_reg < CNT_W'(MAX_ACTIVE_REQS));
        assign afu_rsp_mdata[gi*MDATA_WIDTH +: MDATA_WIDTH] = rsp_mdata_reg;
        assign afu_rsp_data[gi*DATA_WIDTH +: DATA_WIDTH]    = rsp_data_reg;
        assign unused_mdata_top[gi*PW +: PW] = afu_req_mdata[gi*MDATA_WIDTH + LOW_W +: PW];

        // Outstanding count: grant adds, routed response removes (floored at 0), both cancel.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                active_cnt_reg <= '0;
            end else if (grant[gi] && !rsp_hit[gi]) begin
                active_cnt_reg <= active_cnt_reg + CNT_W'(1);
            end else if (!grant[gi] && rsp_hit[gi] && (active_cnt_reg != '0)) begin
                active_cnt_reg <= active_cnt_reg - CNT_W'(1);
            end
        end
    end

`ifdef CCI_MPF_SHIM_REQ_MUX_STATS_EN
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_stat
        stat_cnt_t stat_cnt_reg;

        // Saturating count of grants to this port.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                stat_cnt_reg <= '0;
            end else if (grant[gi] && (stat_cnt_reg != '1)) begin
                stat_cnt_reg <= stat_cnt_reg + stat_cnt_t'(1);
            end
        end

        assign stat_req_count[gi*32 +: 32] = stat_cnt_reg;
    end
`else
    assign stat_req_count = '0;
`endif

endmodule

// File: tb/tb_cci_mpf_shim_req_mux.sv
// Self-checking bench for cci_mpf_shim_req_mux with three ports. A behavioural
// model (pointer integer, per-port count array, arithmetic on tag fields)
// predicts ready each cycle and the registered FIU/AFU outputs after each edge.
module tb_cci_mpf_shim_req_mux;

    localparam int N    = 3;
    localparam int M    = 16;
    localparam int H    = 64;
    localparam int D    = 64;
    localparam int MAXA = 128;
    localparam int PW   = 2;
    localparam int LOW  = 1 << (M - PW);

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     afu_req_valid;
    logic [N*H-1:0]   afu_req_hdr;
    logic [N*M-1:0]   afu_req_mdata;
    logic [N-1:0]     afu_req_ready;
    logic             fiu_req_valid;
    logic [H-1:0]     fiu_req_hdr;
    logic [M-1:0]     fiu_req_mdata;
    logic             fiu_req_almfull;
    logic             fiu_rsp_valid;
    logic [M-1:0]     fiu_rsp_mdata;
    logic [D-1:0]     fiu_rsp_data;
    logic [N-1:0]     afu_rsp_valid;
    logic [N*M-1:0]   afu_rsp_mdata;
    logic [N*D-1:0]   afu_rsp_data;
    logic             tag_error;
    logic [N*32-1:0]  stat_req_count;

    always #5 clk = ~clk;

    cci_mpf_shim_req_mux #(
        .N_PORTS(N), .MDATA_WIDTH(M), .HDR_WIDTH(H), .DATA_WIDTH(D), .MAX_ACTIVE_REQS(MAXA)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .afu_req_valid(afu_req_valid), .afu_req_hdr(afu_req_hdr), .afu_req_mdata(afu_req_mdata),
        .afu_req_ready(afu_req_ready),
        .fiu_req_valid(fiu_req_valid), .fiu_req_hdr(fiu_req_hdr), .fiu_req_mdata(fiu_req_mdata),
        .fiu_req_almfull(fiu_req_almfull),
        .fiu_rsp_valid(fiu_rsp_valid), .fiu_rsp_mdata(fiu_rsp_mdata), .fiu_rsp_data(fiu_rsp_data),
        .afu_rsp_valid(afu_rsp_valid), .afu_rsp_mdata(afu_rsp_mdata), .afu_rsp_data(afu_rsp_data),
        .tag_error(tag_error), .stat_req_count(stat_req_count)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    int     m_ptr;
    int     m_cnt  [N];
    longint m_stat [N];
    logic   m_tagerr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            afu_req_hdr[i*H +: H]   = {$urandom, $urandom};
            afu_req_mdata[i*M +: M] = M'($urandom_range(0, LOW - 1));
        end
    endtask

    // One clock of model prediction and DUT comparison with the inputs currently driven.
    task automatic step();
        int           win;
        int           p;
        int           rport;
        int           pre [N];
        logic [N-1:0] e_ready;
        logic         e_fv;
        logic [H-1:0] e_hdr;
        logic [M-1:0] e_md;
        logic [N-1:0] e_rv;
        logic [M-1:0] e_rmd;
        logic [D-1:0] e_rdata;
        logic [31:0]  e_stat;

        @(negedge clk);
        win     = -1;
        e_ready = '0;
        if (reset_n && !fiu_req_almfull) begin
            for (int off = 0; off < N; off++) begin
                p = (m_ptr + off) % N;
                if (win < 0 && afu_req_valid[p] && m_cnt[p] < MAXA) win = p;
            end
        end
        if (win >= 0) e_ready[win] = 1'b1;
        chk("afu_req_ready", 64'(afu_req_ready), 64'(e_ready));

        e_fv = 1'b0; e_hdr = '0; e_md = '0; e_rv = '0; e_rmd = '0; e_rdata = '0;
        if (!reset_n) begin
            m_ptr    = 0;
            m_tagerr = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_cnt[i]  = 0;
                m_stat[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) pre[i] = m_cnt[i];
            if (win >= 0) begin
                e_fv  = 1'b1;
                e_hdr = afu_req_hdr[win*H +: H];
                e_md  = M'(int'(afu_req_mdata[win*M +: M]) % LOW + win * LOW);
                if (m_stat[win] < 64'hFFFF_FFFF) m_stat[win]++;
                m_ptr = (win + 1) % N;
                $display("grant port=%0d hdr=%h mdata=%h", win, e_hdr, e_md);
            end
            rport = -1;
            if (fiu_rsp_valid) begin
                rport = int'(fiu_rsp_mdata) / LOW;
                if (rport < N) begin
                    e_rv[rport] = 1'b1;
                    e_rmd       = M'(int'(fiu_rsp_mdata) % LOW);
                    e_rdata     = fiu_rsp_data;
                end else begin
                    m_tagerr = 1'b1;
                    rport    = -1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (win == i && rport == i) m_cnt[i] = pre[i];
                else if (win == i)          m_cnt[i] = pre[i] + 1;
                else if (rport == i)        m_cnt[i] = (pre[i] > 0) ? pre[i] - 1 : 0;
            end
        end

        @(posedge clk);
        #1;
        chk("fiu_req_valid", 64'(fiu_req_valid), 64'(e_fv));
        if (e_fv) begin
            chk("fiu_req_hdr", 64'(fiu_req_hdr), 64'(e_hdr));
            chk("fiu_req_mdata", 64'(fiu_req_mdata), 64'(e_md));
        end
        chk("afu_rsp_valid", 64'(afu_rsp_valid), 64'(e_rv));
        for (int i = 0; i < N; i++) begin
            if (e_rv[i]) begin
                chk("afu_rsp_mdata", 64'(afu_rsp_mdata[i*M +: M]), 64'(e_rmd));
                chk("afu_rsp_data", 64'(afu_rsp_data[i*D +: D]), 64'(e_rdata));
            end
        end
        chk("tag_error", 64'(tag_error), 64'(m_tagerr));
        for (int i = 0; i < N; i++) begin
`ifdef CCI_MPF_SHIM_REQ_MUX_STATS_EN
            e_stat = 32'(m_stat[i]);
`else
            e_stat = 32'd0;
`endif
            chk("stat_req_count", 64'(stat_req_count[i*32 +: 32]), 64'(e_stat));
        end
    endtask

    task automatic run(input int n, input logic [N-1:0] valid, input logic rv, input logic [M-1:0] rmd);
        for (int k = 0; k < n; k++) begin
            rand_payload();
            afu_req_valid = valid;
            fiu_rsp_valid = rv;
            fiu_rsp_mdata = rmd;
            fiu_rsp_data  = {$urandom, $urandom};
            step();
        end
        fiu_rsp_valid = 1'b0;
    endtask

    initial begin
        int port;
        m_ptr    = 0;
        m_tagerr = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_stat[i] = 0;
        end
        reset_n         = 1'b0;
        afu_req_valid   = '0;
        afu_req_hdr     = '0;
        afu_req_mdata   = '0;
        fiu_req_almfull = 1'b0;
        fiu_rsp_valid   = 1'b0;
        fiu_rsp_mdata   = '0;
        fiu_rsp_data    = '0;

        // Reset with requests and a bad-tag response pending: all outputs held quiet.
        run(3, 3'b111, 1'b1, 16'hC001);
        reset_n = 1'b1;

        // Two ports valid continuously: grants alternate 0,1 with tag 0,1.
        run(8, 3'b011, 1'b0, 16'h0000);

        // Responses routed by tag; tag bits cleared on the AFU side.
        run(1, 3'b000, 1'b1, 16'h8005);
        run(1, 3'b000, 1'b1, 16'h4005);
        run(1, 3'b001, 1'b1, 16'h0007);

        // Almost-full blocks all grants; arbitration resumes after it drops.
        fiu_req_almfull = 1'b1;
        run(10, 3'b111, 1'b0, 16'h0000);
        fiu_req_almfull = 1'b0;
        run(4, 3'b111, 1'b0, 16'h0000);

        // Out-of-range tag is dropped and latches tag_error until reset.
        run(1, 3'b000, 1'b1, 16'hC123);
        run(3, 3'b101, 1'b0, 16'h0000);
        reset_n = 1'b0;
        run(2, 3'b111, 1'b0, 16'h0000);
        reset_n = 1'b1;

        // Port 1 fills to the limit while port 0 keeps being answered and served.
        run(300, 3'b011, 1'b1, 16'h0000);
        run(5, 3'b010, 1'b0, 16'h0000);
        run(1, 3'b010, 1'b1, 16'h4000);
        run(3, 3'b010, 1'b0, 16'h0000);

        // Port 0 at five outstanding, grant and response together, then fill to the limit.
        reset_n = 1'b0;
        run(1, 3'b000, 1'b0, 16'h0000);
        reset_n = 1'b1;
        run(5, 3'b001, 1'b0, 16'h0000);
        run(1, 3'b001, 1'b1, 16'h0000);
        run(125, 3'b001, 1'b0, 16'h0000);

        // Randomized traffic with occasional almfull, bad tags and resets.
        for (int k = 0; k < 800; k++) begin
            rand_payload();
            afu_req_valid   = N'($urandom);
            fiu_req_almfull = ($urandom_range(0, 4) == 0);
            fiu_rsp_valid   = 1'($urandom_range(0, 1));
            port            = ($urandom_range(0, 31) == 0) ? 3 : int'($urandom_range(0, N - 1));
            fiu_rsp_mdata   = M'(port * LOW + int'($urandom_range(0, LOW - 1)));
            fiu_rsp_data    = {$urandom, $urandom};
            reset_n         = (k % 250) != 249;
            step();
        end
        reset_n         = 1'b1;
        fiu_req_almfull = 1'b0;
        run(2, 3'b000, 1'b1, 16'hC000);
        reset_n = 1'b0;
        run(2, 3'b000, 1'b0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
